pwm_capture: RTL and testbench

- Receive-side counterpart of the PWM generator. Measures an incoming PWM waveform and reports its period and active-phase width in prescaled ticks.
- Uses the same 2^prescale tick semantics as the generator's counter, so a generator/capture loopback reads back its own PERIOD and compare settings.
- Sits beside the generator. Results go to the register block as read-only values.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_edge_sync.sv | 29 ++
 rtl/pwm_capture.sv | 100 ++++++++++
 tb/tb_pwm_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and FSM encoding shared by the PWM generator and capture blocks
package pwm_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int PRESCALE_MAX = 15;
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] MEAS_ACT   = 2'd1;
    localparam logic [1:0] MEAS_INACT = 2'd2;
    function automatic logic [3:0] clamp_ps(input logic [7:0] ps);
        return (ps > 8'(PRESCALE_MAX)) ? 4'(PRESCALE_MAX) : ps[3:0];
    endfunction
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: input synchroniser with polarity-aware start/end edge detect
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    input  logic edge_pol,
    output logic start_edge,
    output logic end_edge
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    logic rise;
    logic fall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign fall = ~sync[SYNC_STAGES-1] & prev;
    assign start_edge = edge_pol ? rise : fall;
    assign end_edge = edge_pol ? fall : rise;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active-phase width of a PWM input in prescaled ticks
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    input  logic             edge_pol,
    input  logic [7:0]       prescale,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] period_val,
    output logic [CNT_W-1:0] high_val,
    output logic             meas_valid,
    output logic             locked,
    output logic             ovf
);
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cnt_inc;
    logic [PRESCALE_MAX-1:0] pre;
    logic [PRESCALE_MAX-1:0] mask;
    logic [3:0] ps_q;
    logic pol_q;
    logic start_edge;
    logic end_edge;
    logic tick;
    logic ovf_hit;
    // idle follows the live polarity so the very first start edge is found
    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .edge_pol((state == IDLE) ? edge_pol : pol_q),
        .start_edge(start_edge),
        .end_edge(end_edge)
    );
    assign mask = ~({PRESCALE_MAX{1'b1}} << ps_q);
    assign tick = (pre == mask);
    assign cnt_inc = cnt + CNT_W'(tick);
    assign ovf_hit = (state != IDLE) && tick && (&cnt);
    assign locked = (state != IDLE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            shadow <= '0;
            pre <= '0;
            ps_q <= '0;
            pol_q <= 1'b0;
            period_val <= '0;
            high_val <= '0;
            meas_valid <= 1'b0;
            ovf <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clr_ovf) ovf <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt <= '0;
                shadow <= '0;
                pre <= '0;
            end else if (state == IDLE) begin
                cnt <= '0;
                pre <= '0;
                if (start_edge) begin
                    state <= MEAS_ACT;
                    pol_q <= edge_pol;
                    ps_q <= clamp_ps(prescale);
                end
            end else if (ovf_hit) begin
                ovf <= 1'b1;
                state <= IDLE;
                cnt <= '0;
                shadow <= '0;
                pre <= '0;
            end else if (state == MEAS_INACT && start_edge) begin
                period_val <= cnt_inc;
                high_val <= shadow;
                meas_valid <= 1'b1;
                cnt <= '0;
                pre <= '0;
                state <= MEAS_ACT;
                pol_q <= edge_pol;
                ps_q <= clamp_ps(prescale);
            end else begin
                cnt <= cnt_inc;
                pre <= tick ? '0 : pre + 1'b1;
                if (state == MEAS_ACT && end_edge) begin
                    shadow <= cnt_inc;
                    state <= MEAS_INACT;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture
module tb_pwm_capture;
    localparam int W = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic pwm_in = 1'b0;
    logic edge_pol = 1'b1;
    logic [7:0] prescale = 8'd0;
    logic clr_ovf = 1'b0;
    logic [W-1:0] period_val;
    logic [W-1:0] high_val;
    logic meas_valid;
    logic locked;
    logic ovf;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int vcnt = 0;
    int last_cyc = 0;
    int gap = 0;
    int snap = 0;
    logic seen = 1'b0;

    // narrow counter keeps overflow scenarios short
    pwm_capture #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pwm_in(pwm_in),
        .edge_pol(edge_pol),
        .prescale(prescale),
        .clr_ovf(clr_ovf),
        .period_val(period_val),
        .high_val(high_val),
        .meas_valid(meas_valid),
        .locked(locked),
        .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (meas_valid) begin
            vcnt <= vcnt + 1;
            gap <= cyc - last_cyc;
            last_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic per(input int hi, input int lo);
        pwm_in = 1'b1;
        step(hi);
        pwm_in = 1'b0;
        step(lo);
    endtask

    initial begin
        #12;
        chk("rst_period", int'(period_val), 0);
        chk("rst_high", int'(high_val), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_ovf", int'(ovf), 0);
        step(1);
        rst = 1'b0;
        en = 1'b1;
        step(10);
        // test 1: 30/70 active-high at prescale 0
        per(30, 70);
        chk("t1_no_valid_yet", vcnt, 0);
        per(30, 70);
        per(30, 70);
        chk("t1_valid_cnt", vcnt, 2);
        chk("t1_period", int'(period_val), 100);
        chk("t1_high", int'(high_val), 30);
        chk("t1_gap", gap, 100);
        chk("t1_locked", int'(locked), 1);
        // test 2: prescale 2 applies from the next start edge
        prescale = 8'd2;
        per(40, 60);
        per(40, 60);
        chk("t2_period", int'(period_val), 25);
        chk("t2_high", int'(high_val), 10);
        // test 3: falling edge starts the period, active phase is low
        prescale = 8'd0;
        edge_pol = 1'b0;
        per(30, 70);
        per(30, 70);
        per(30, 70);
        chk("t3_period", int'(period_val), 100);
        chk("t3_high", int'(high_val), 70);
        chk("t3_gap", gap, 100);
        // test 4: held-high input times out
        en = 1'b0;
        step(3);
        edge_pol = 1'b1;
        en = 1'b1;
        step(3);
        snap = vcnt;
        pwm_in = 1'b1;
        step(1015);
        chk("t4_no_ovf_early", int'(ovf), 0);
        chk("t4_locked_early", int'(locked), 1);
        step(20);
        chk("t4_ovf", int'(ovf), 1);
        chk("t4_unlocked", int'(locked), 0);
        chk("t4_no_valid", vcnt, snap);
        chk("t4_period_hold", int'(period_val), 100);
        chk("t4_high_hold", int'(high_val), 70);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t4_ovf_cleared", int'(ovf), 0);
        pwm_in = 1'b0;
        step(5);
        clr_ovf = 1'b1;
        pwm_in = 1'b1;
        for (int i = 0; i < 1100 && !seen; i++) begin
            step(1);
            if (ovf) seen = 1'b1;
        end
        chk("t4_set_beats_clear", int'(seen), 1);
        step(1);
        chk("t4_clear_after", int'(ovf), 0);
        clr_ovf = 1'b0;
        // test 5: enable dropped in the inactive phase
        pwm_in = 1'b0;
        step(10);
        per(40, 60);
        per(40, 60);
        pwm_in = 1'b1;
        step(40);
        pwm_in = 1'b0;
        step(20);
        snap = vcnt;
        chk("t5_pre_period", int'(period_val), 100);
        chk("t5_pre_high", int'(high_val), 40);
        en = 1'b0;
        step(40);
        per(30, 70);
        chk("t5_off_no_valid", vcnt, snap);
        chk("t5_off_unlocked", int'(locked), 0);
        chk("t5_off_period", int'(period_val), 100);
        chk("t5_off_high", int'(high_val), 40);
        en = 1'b1;
        per(30, 70);
        chk("t5_first_period_pending", vcnt, snap);
        per(30, 70);
        chk("t5_valid_after", vcnt, snap + 1);
        chk("t5_period", int'(period_val), 100);
        chk("t5_high", int'(high_val), 30);
        // test 6: asynchronous reset during the active phase
        pwm_in = 1'b1;
        step(10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_period", int'(period_val), 0);
        chk("t6_high", int'(high_val), 0);
        chk("t6_locked", int'(locked), 0);
        chk("t6_ovf", int'(ovf), 0);
        chk("t6_valid", int'(meas_valid), 0);
        step(20);
        pwm_in = 1'b0;
        step(10);
        rst = 1'b0;
        snap = vcnt;
        step(60);
        per(30, 70);
        per(30, 70);
        chk("t6_valid_cnt", vcnt, snap + 1);
        chk("t6_period_after", int'(period_val), 100);
        chk("t6_high_after", int'(high_val), 30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
